// File: rtl/fpu_sequencer.sv
// fpu_sequencer: runs one floating-point operation at a time between the
// execute stage and the FPU controller. Captures op/operands on acceptance,
// drives the operand strobe/ack handshakes, waits for the result, and
// returns it with a one-cycle done pulse. Illegal ops are rejected without
// touching the FPU; a watchdog bounds transactions that never complete.
module fpu_sequencer #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    // Core request side
    input  logic        req,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        illegal,
    output logic        timeout,
    // FPU controller side
    output logic [3:0]  fpu_op,
    output logic [31:0] fpu_in1,
    output logic [31:0] fpu_in2,
    output logic        fpu_in1_stb,
    output logic        fpu_in2_stb,
    input  logic        fpu_in1_ack,
    input  logic        fpu_in2_ack,
    input  logic [31:0] fpu_out,
    input  logic        fpu_out_stb,
    output logic        fpu_out_ack
);

    localparam int unsigned OP_W   = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    // Highest op code the FPU controller understands (fle)
    localparam logic [OP_W-1:0] OP_LAST = OP_W'(4'b1010);

    // Watchdog fires on the edge that would bring the count to TIMEOUT
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state;
    logic              sent1;
    logic              sent2;
    logic [CNT_W-1:0]  wd_cnt;

    logic              hs1;
    logic              hs2;
    logic              both_sent;
    logic              wd_expire;
    logic              in_flight;

    // Handshake and watchdog decode from registered state and this cycle's acks
    always_comb begin
        hs1       = fpu_in1_stb & fpu_in1_ack;
        hs2       = fpu_in2_stb & fpu_in2_ack;
        both_sent = (sent1 | hs1) & (sent2 | hs2);
        in_flight = (state == ST_SEND) || (state == ST_WAIT);
        wd_expire = in_flight && (wd_cnt == WD_LAST);
    end

    // Sequencer state, handshake flags, watchdog and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            sent1       <= 1'b0;
            sent2       <= 1'b0;
            wd_cnt      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            illegal     <= 1'b0;
            timeout     <= 1'b0;
            fpu_op      <= '0;
            fpu_in1     <= '0;
            fpu_in2     <= '0;
            fpu_in1_stb <= 1'b0;
            fpu_in2_stb <= 1'b0;
            fpu_out_ack <= 1'b0;
        end else begin
            done <= 1'b0;

            if (wd_expire) begin
                // Abort wins over any handshake landing on the same edge
                state       <= ST_DONE;
                fpu_in1_stb <= 1'b0;
                fpu_in2_stb <= 1'b0;
                fpu_out_ack <= 1'b0;
                result      <= '0;
                timeout     <= 1'b1;
                done        <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (req) begin
                            busy    <= 1'b1;
                            result  <= '0;
                            timeout <= 1'b0;
                            if (req_op <= OP_LAST) begin
                                fpu_op      <= req_op;
                                fpu_in1     <= req_rs1;
                                fpu_in2     <= req_rs2;
                                illegal     <= 1'b0;
                                sent1       <= 1'b0;
                                sent2       <= 1'b0;
                                wd_cnt      <= '0;
                                fpu_in1_stb <= 1'b1;
                                fpu_in2_stb <= 1'b1;
                                state       <= ST_SEND;
                            end else begin
                                // Rejected: report straight away, FPU untouched
                                illegal <= 1'b1;
                                done    <= 1'b1;
                                state   <= ST_DONE;
                            end
                        end
                    end

                    ST_SEND: begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                        if (hs1) begin
                            sent1       <= 1'b1;
                            fpu_in1_stb <= 1'b0;
                        end
                        if (hs2) begin
                            sent2       <= 1'b1;
                            fpu_in2_stb <= 1'b0;
                        end
                        if (both_sent) begin
                            fpu_out_ack <= 1'b1;
                            state       <= ST_WAIT;
                        end
                    end

                    ST_WAIT: begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                        if (fpu_out_stb) begin
                            result      <= fpu_out;
                            fpu_out_ack <= 1'b0;
                            done        <= 1'b1;
                            state       <= ST_DONE;
                        end
                    end

                    ST_DONE: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end

                    default: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Operand width is fixed by the FPU controller interface
    if (DATA_W != 32) begin : g_width_guard
        logic unused_guard;
        assign unused_guard = 1'b0;
    end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Testbench for fpu_sequencer: a timed FPU-controller model drives acks and
// results; expected behaviour per cycle is derived from handshake latencies.
// Two instances: default watchdog, and a short watchdog (TIMEOUT=8).
module tb_fpu_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic        sel;
    logic [3:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        in1_ack;
    logic        in2_ack;
    logic        out_stb;
    logic [31:0] fpu_out;

    logic        req_a, req_b;
    logic        busy_a, done_a, illegal_a, timeout_a, stb1_a, stb2_a, oack_a;
    logic        busy_b, done_b, illegal_b, timeout_b, stb1_b, stb2_b, oack_b;
    logic [31:0] result_a, in1_a, in2_a, result_b, in1_b, in2_b;
    logic [3:0]  op_a, op_b;

    logic        o_busy, o_done, o_illegal, o_timeout, o_stb1, o_stb2, o_oack;
    logic [31:0] o_result, o_in1, o_in2;
    logic [3:0]  o_op;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign req_a = req & ~sel;
    assign req_b = req & sel;

    assign o_busy    = sel ? busy_b    : busy_a;
    assign o_done    = sel ? done_b    : done_a;
    assign o_illegal = sel ? illegal_b : illegal_a;
    assign o_timeout = sel ? timeout_b : timeout_a;
    assign o_stb1    = sel ? stb1_b    : stb1_a;
    assign o_stb2    = sel ? stb2_b    : stb2_a;
    assign o_oack    = sel ? oack_b    : oack_a;
    assign o_result  = sel ? result_b  : result_a;
    assign o_in1     = sel ? in1_b     : in1_a;
    assign o_in2     = sel ? in2_b     : in2_a;
    assign o_op      = sel ? op_b      : op_a;

    fpu_sequencer dut_a (
        .clk(clk), .reset_n(reset_n),
        .req(req_a), .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .busy(busy_a), .done(done_a), .result(result_a),
        .illegal(illegal_a), .timeout(timeout_a),
        .fpu_op(op_a), .fpu_in1(in1_a), .fpu_in2(in2_a),
        .fpu_in1_stb(stb1_a), .fpu_in2_stb(stb2_a),
        .fpu_in1_ack(in1_ack), .fpu_in2_ack(in2_ack),
        .fpu_out(fpu_out), .fpu_out_stb(out_stb), .fpu_out_ack(oack_a)
    );

    fpu_sequencer #(.TIMEOUT(8)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .req(req_b), .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .busy(busy_b), .done(done_b), .result(result_b),
        .illegal(illegal_b), .timeout(timeout_b),
        .fpu_op(op_b), .fpu_in1(in1_b), .fpu_in2(in2_b),
        .fpu_in1_stb(stb1_b), .fpu_in2_stb(stb2_b),
        .fpu_in1_ack(in1_ack), .fpu_in2_ack(in2_ack),
        .fpu_out(fpu_out), .fpu_out_stb(out_stb), .fpu_out_ack(oack_b)
    );

    // One transaction: controller acks operand n from cycle a_n after
    // acceptance, shows the result from cycle o. Cycle 0 is the first
    // cycle after the accepting edge.
    task automatic run_txn(input logic s, input logic [3:0] op,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input int a1, input int a2, input int o,
                           input logic [31:0] dout, input bit hold,
                           input string tag);
        int          lim, s_end, need, dk;
        bit          legal, to_exp;
        logic [31:0] exp_res;
        logic [4:0]  exp_ctrl, got_ctrl;
        legal = (op <= 4'd10);
        lim   = s ? 8 : 1023;
        s_end = (a1 > a2) ? a1 : a2;
        need  = ((s_end + 1 > o) ? s_end + 1 : o) + 1;
        if (legal) begin
            to_exp  = (need >= lim);
            dk      = to_exp ? lim : need;
            exp_res = to_exp ? 32'h0 : dout;
        end else begin
            to_exp  = 1'b0;
            dk      = 0;
            exp_res = 32'h0;
        end
        @(negedge clk);
        sel = s; req = 1'b1; req_op = op; req_rs1 = r1; req_rs2 = r2;
        in1_ack = 1'b0; in2_ack = 1'b0; out_stb = 1'b0; fpu_out = $urandom;
        for (int k = 0; k <= dk + 1; k++) begin
            @(negedge clk);
            exp_ctrl = {k <= dk, k == dk,
                        legal && k <= a1 && k < dk,
                        legal && k <= a2 && k < dk,
                        legal && k > s_end && k < dk};
            got_ctrl = {o_busy, o_done, o_stb1, o_stb2, o_oack};
            checks++;
            if (got_ctrl !== exp_ctrl) begin
                errors++;
                $display("FAIL %s ctrl k=%0d got=%b exp=%b (busy,done,stb1,stb2,oack)",
                         tag, k, got_ctrl, exp_ctrl);
            end
            if (legal) begin
                checks++;
                if ({o_op, o_in1, o_in2} !== {op, r1, r2}) begin
                    errors++;
                    $display("FAIL %s operands k=%0d got=%h/%h/%h exp=%h/%h/%h",
                             tag, k, o_op, o_in1, o_in2, op, r1, r2);
                end
            end
            if (k >= dk) begin
                checks++;
                if ({o_result, o_illegal, o_timeout} !== {exp_res, !legal, to_exp}) begin
                    errors++;
                    $display("FAIL %s result k=%0d got=%h ill=%b to=%b exp=%h ill=%b to=%b",
                             tag, k, o_result, o_illegal, o_timeout,
                             exp_res, !legal, to_exp);
                end
            end
            if (!hold) req = 1'b0;
            else if (k == 0) req_rs1 = r1 ^ 32'h0F0F_0F0F;
            in1_ack = (k >= a1);
            in2_ack = (k >= a2);
            out_stb = (k >= o);
            fpu_out = (k >= o) ? dout : $urandom;
        end
    endtask

    task automatic test_reset();
        logic [106:0] v;
        for (int i = 0; i < 2; i++) begin
            sel = (i == 1);
            #1;
            v = {o_busy, o_done, o_result, o_illegal, o_timeout, o_op,
                 o_in1, o_in2, o_stb1, o_stb2, o_oack};
            checks++;
            if (v !== '0) begin
                errors++;
                $display("FAIL reset_state dut=%0d got=%h exp=0", i, v);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_fsgnj();
        logic [31:0] a, b;
        a = 32'h3F80_0000; b = 32'h8000_0000;
        run_txn(1'b0, 4'b0110, a, b, 0, 0, 0, {b[31], a[30:0]}, 1'b0, "fsgnj");
        checks++;
        if (o_result !== 32'hBF80_0000) begin
            errors++;
            $display("FAIL fsgnj_value got=%h exp=%h", o_result, 32'hBF80_0000);
        end
    endtask

    task automatic test_fadd();
        run_txn(1'b0, 4'b0000, 32'h3F80_0000, 32'h4000_0000, 2, 4, 10,
                32'h4040_0000, 1'b0, "fadd");
    endtask

    task automatic test_illegal();
        run_txn(1'b0, 4'b1100, 32'hDEAD_BEEF, 32'h1234_5678, 0, 0, 0,
                32'hFFFF_FFFF, 1'b0, "illegal");
        run_txn(1'b0, 4'b0111, 32'h4000_0000, 32'h0000_0000, 1, 0, 0,
                32'hC000_0000, 1'b0, "after_illegal");
    endtask

    task automatic test_timeout();
        run_txn(1'b1, 4'b0011, 32'h4000_0000, 32'h4000_0000, 0, 0, 1000,
                32'h3F80_0000, 1'b0, "timeout");
        run_txn(1'b1, 4'b0000, 32'h1, 32'h2, 7, 3, 7, 32'h5, 1'b0, "timeout_vs_hs");
        run_txn(1'b1, 4'b0000, 32'h1, 32'h2, 3, 2, 6, 32'h6, 1'b0, "just_in_time");
    endtask

    task automatic test_reset_mid();
        logic [106:0] v;
        @(negedge clk);
        sel = 1'b0; req = 1'b1; req_op = 4'b0011;
        req_rs1 = 32'h40C0_0000; req_rs2 = 32'h4000_0000;
        in1_ack = 1'b1; in2_ack = 1'b1; out_stb = 1'b0;
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        v = {o_busy, o_done, o_result, o_illegal, o_timeout, o_op,
             o_in1, o_in2, o_stb1, o_stb2, o_oack};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait got=%h exp=0", v);
        end
        out_stb = 1'b1; fpu_out = 32'h4040_0000;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({o_busy, o_done} !== 2'b00) begin
                errors++;
                $display("FAIL reset_no_done k=%0d got=%b exp=00", k, {o_busy, o_done});
            end
        end
        out_stb = 1'b0;
        run_txn(1'b0, 4'b1000, 32'h4000_0000, 32'h4000_0000, 0, 0, 0,
                32'h0000_0001, 1'b0, "feq_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1;
        r1 = 32'h40C0_0000;
        run_txn(1'b0, 4'b0011, r1, 32'h4000_0000, 1, 2, 6, 32'h4040_0000,
                1'b1, "fdiv_hold");
        in1_ack = 1'b1; in2_ack = 1'b1; out_stb = 1'b1; fpu_out = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if ({o_busy, o_done, o_in1} !== {2'b10, r1 ^ 32'h0F0F_0F0F}) begin
            errors++;
            $display("FAIL second_accept got=%b%b/%h exp=10/%h",
                     o_busy, o_done, o_in1, r1 ^ 32'h0F0F_0F0F);
        end
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({o_done, o_result} !== {1'b1, 32'h1234_5678}) begin
            errors++;
            $display("FAIL second_done got=%b/%h exp=1/12345678", o_done, o_result);
        end
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL second_idle got=%b exp=0", o_busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_txn(1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom,
                    $urandom_range(0, 6), $urandom_range(0, 6),
                    $urandom_range(0, 12), $urandom, 1'b0, "rand_a");
        end
        for (int i = 0; i < 12; i++) begin
            run_txn(1'b1, 4'($urandom_range(0, 10)), $urandom, $urandom,
                    $urandom_range(0, 9), $urandom_range(0, 9),
                    $urandom_range(0, 14), $urandom, 1'b0, "rand_b");
        end
    endtask

    initial begin
        reset_n = 1'b0; req = 1'b0; sel = 1'b0; req_op = '0;
        req_rs1 = '0; req_rs2 = '0; in1_ack = 1'b0; in2_ack = 1'b0;
        out_stb = 1'b0; fpu_out = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_fsgnj();
        test_fadd();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_sequencer.md
Name: fpu_sequencer

Overview:
- Sequences one floating-point operation at a time between the core's execute stage and the FPU controller.
- Accepts a request pulse with op and operands, then holds op and operands stable for the whole transaction.
- Drives the FPU strobe/ack handshakes, captures the result and returns it with a one-cycle done pulse.
- Rejects illegal ops and bounds hung transactions with a watchdog timeout.

Parameters:
- TIMEOUT, 1023, maximum cycles spent in SEND+WAIT before the transaction is aborted (must be ≥2). Counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- req  in  1  core request; sampled only while busy=0
- req_op  in  4  FPU op code (0000 fadd … 1010 fle)
- req_rs1  in  32  operand 1
- req_rs2  in  32  operand 2
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; result, illegal and timeout valid
- result  out  32  captured FPU result; held until the next accepted req
- illegal  out  1  op ≥ 1011 rejected; held like result
- timeout  out  1  watchdog abort; held like result
- fpu_op  out  4  registered op presented to the FPU controller
- fpu_in1  out  32  registered operand 1
- fpu_in2  out  32  registered operand 2
- fpu_in1_stb  out  1  operand-1 strobe
- fpu_in2_stb  out  1  operand-2 strobe
- fpu_in1_ack  in  1  operand-1 accepted
- fpu_in2_ack  in  1  operand-2 accepted
- fpu_out  in  32  FPU result
- fpu_out_stb  in  1  result valid
- fpu_out_ack  out  1  result consumed

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All outputs 0: fpu_op=0000, operands 0, strobes 0, fpu_out_ack 0, result 0, flags 0.
  - Watchdog counter 0, sent1/sent2 flags 0.
  - Reset mid-transaction aborts it immediately; no done pulse.
- States: IDLE, SEND, WAIT, DONE. busy = (state != IDLE).
- IDLE:
  - On req=1 with req_op ≤ 1010: register op/rs1/rs2 into fpu_op/fpu_in1/fpu_in2; clear result/illegal/timeout, sent1, sent2 and the counter; go to SEND.
  - On req=1 with req_op ≥ 1011: no FPU handshake, result=0, illegal=1, timeout=0; go to DONE.
- SEND:
  - fpu_in1_stb = ~sent1 and fpu_in2_stb = ~sent2, each decoded from registered state.
  - A handshake completes on an edge where stb=1 and ack=1; that edge sets the matching sent flag.
  - When both handshakes are complete (including both on the same edge), go to WAIT.
  - Single-operand ops (0100, 0101) need no special case: the controller mirrors in1_ack onto in2_ack.
- WAIT:
  - fpu_out_ack=1 throughout.
  - On an edge with fpu_out_stb=1, capture fpu_out into result and go to DONE.
  - Combinational ops (0110–1010) therefore spend exactly 1 cycle in SEND and 1 in WAIT.
- DONE:
  - done=1 for exactly one cycle; all strobes and fpu_out_ack are 0.
  - Next state is IDLE. req is ignored while in DONE.
- Latency: req accepted at edge E0 → SEND → WAIT → done high in the cycle after E2 (3 cycles minimum). Arithmetic ops add their FPU latency.
- fpu_op and fpu_in1/fpu_in2 stay stable from the edge after acceptance until the next accepted req. The controller muxes by op, so op must never change mid-transaction.
- Watchdog:
  - The counter increments each cycle in SEND or WAIT.
  - On reaching TIMEOUT, go to DONE with timeout=1, result=0; strobes and fpu_out_ack drop that edge.
  - A timeout has priority over a handshake completing on the same edge.
  - After a timeout the FPU submodule state is undefined; software must reset the FPU.
- Req arriving while busy=1 is dropped. The core must hold req until it observes busy=0 and then sample done.
- Output timing: all outputs are registered or decoded from registered state only; no input-to-output combinational paths.

Test Plan:
- fsgnj (op 0110), rs1=0x3F800000, rs2=0x80000000, controller acks/out_stb tied 1 → done exactly 3 cycles after req, result=0xBF800000, illegal=0, timeout=0.
- fadd (op 0000), 1.0+2.0, FPU model with in1_ack after 2 cycles, in2_ack after 4, out_stb after 10 → strobes drop individually on their handshake edge; result=0x40400000; fpu_op/fpu_in stable throughout.
- op 1100 request → no strobes asserted, done in 1 cycle (cycle after E0), illegal=1, result=0; next valid op clears illegal.
- TIMEOUT=8, FPU model never asserts out_stb → done with timeout=1 after 8 cycles in SEND+WAIT, result=0, fpu_out_ack low after abort.
- reset_n pulsed low mid-WAIT → all outputs immediately 0, state IDLE, no done; a new feq (rs1=rs2=0x40000000) afterwards returns result=0x00000001.
- req held high during a busy fdiv → only one transaction executed; second req accepted only after busy falls.
